// File: rtl/edge_pkg.sv
// Shared types and helpers for the edgegen pulse generator: FSM state encoding,
// idle output level and timer sizing.
package edge_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GAP    = 2'd2
  } edgegen_state_t;

  function automatic logic idle_level(input int unsigned pos_edge);
    return (pos_edge == 0) ? 1'b1 : 1'b0;
  endfunction

  // Timer must hold the larger of the two reload values (count - 1).
  function automatic int unsigned timer_width(input int unsigned high_cycles,
                                              input int unsigned low_cycles);
    int unsigned m;
    m = (high_cycles > low_cycles) ? high_cycles : low_cycles;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up/down counter that saturates at all-ones, floors at zero, holds on
// simultaneous inc/dec and strobes o_overflow when an increment is dropped.
module sat_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic [WIDTH-1:0] o_count,
  output logic             o_overflow
);

  logic [WIDTH-1:0] r_count;
  logic             w_at_max;
  logic             w_at_zero;

  assign w_at_max  = &r_count;
  assign w_at_zero = ~|r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_inc && !i_dec && !w_at_max) begin
      r_count <= r_count + 1'b1;
    end else if (i_dec && !i_inc && !w_at_zero) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_count    = r_count;
  assign o_overflow = i_inc && !i_dec && w_at_max;

endmodule

// File: rtl/edgegen.sv
// Turns single-cycle trigger strobes into fixed-width pulses with a guaranteed
// idle gap, queueing triggers that arrive mid-pulse. Optional macro
// EDGEGEN_OVERFLOW_EN adds a sticky out_overflow flag for dropped triggers.
module edgegen
  import edge_pkg::*;
#(
  parameter int unsigned HIGH_CYCLES  = 4,
  parameter int unsigned LOW_CYCLES   = 4,
  parameter int unsigned PENDING_BITS = 4,
  parameter int unsigned POS_EDGE     = 1
) (
  input  logic                    in_clk,
  input  logic                    in_rst,
  input  logic                    in_trigger,
  output logic                    out_signal,
  output logic                    out_busy,
  output logic [PENDING_BITS-1:0] out_pending
`ifdef EDGEGEN_OVERFLOW_EN
  ,
  output logic                    out_overflow
`endif
);

  localparam int unsigned     TW       = timer_width(HIGH_CYCLES, LOW_CYCLES);
  localparam logic [TW-1:0]   HI_LOAD  = TW'(HIGH_CYCLES - 1);
  localparam logic [TW-1:0]   LO_LOAD  = TW'(LOW_CYCLES - 1);
  localparam logic            IDLE_LVL = idle_level(POS_EDGE);

  edgegen_state_t          r_state;
  edgegen_state_t          w_state_nxt;
  logic [TW-1:0]           r_timer;
  logic [TW-1:0]           w_timer_nxt;
  logic                    r_signal;
  logic                    w_inc;
  logic                    w_dec;
  logic                    w_ovf;
  logic                    w_pend_nz;
  logic [PENDING_BITS-1:0] w_pending;

  assign w_pend_nz = |w_pending;

  // Only a trigger that can start a pulse on its own bypasses the queue.
  assign w_inc = in_trigger && !((r_state == IDLE) && !w_pend_nz);

  sat_counter #(
    .WIDTH(PENDING_BITS)
  ) u_pending (
    .i_clk     (in_clk),
    .i_rst     (in_rst),
    .i_inc     (w_inc),
    .i_dec     (w_dec),
    .o_count   (w_pending),
    .o_overflow(w_ovf)
  );

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      r_state  <= IDLE;
      r_timer  <= '0;
      r_signal <= IDLE_LVL;
    end else begin
      r_state  <= w_state_nxt;
      r_timer  <= w_timer_nxt;
      r_signal <= (w_state_nxt == ACTIVE) ? ~IDLE_LVL : IDLE_LVL;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_dec       = 1'b0;
    unique case (r_state)
      IDLE: begin
        // A trigger counted in the final gap cycle is replayed from here.
        if (w_pend_nz) begin
          w_state_nxt = ACTIVE;
          w_timer_nxt = HI_LOAD;
          w_dec       = 1'b1;
        end else if (in_trigger) begin
          w_state_nxt = ACTIVE;
          w_timer_nxt = HI_LOAD;
        end
      end
      ACTIVE: begin
        if (r_timer == '0) begin
          w_state_nxt = GAP;
          w_timer_nxt = LO_LOAD;
        end else begin
          w_timer_nxt = r_timer - 1'b1;
        end
      end
      GAP: begin
        if (r_timer == '0) begin
          if (w_pend_nz) begin
            w_state_nxt = ACTIVE;
            w_timer_nxt = HI_LOAD;
            w_dec       = 1'b1;
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_timer_nxt = r_timer - 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_timer_nxt = '0;
      end
    endcase
  end

  assign out_signal  = r_signal;
  assign out_busy    = (r_state != IDLE) || w_pend_nz;
  assign out_pending = w_pending;

`ifdef EDGEGEN_OVERFLOW_EN
  logic r_overflow;

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      r_overflow <= 1'b0;
    end else if (w_ovf) begin
      r_overflow <= 1'b1;
    end
  end

  assign out_overflow = r_overflow;
`else
  logic w_ovf_unused;
  assign w_ovf_unused = w_ovf;
`endif

endmodule

// File: tb/tb_edgegen.sv
// Bench for edgegen: two configurations share one trigger stream and are
// compared every cycle against a pulse-schedule model.
module tb_edgegen;

  logic       in_clk = 1'b0;
  logic       in_rst;
  logic       in_trigger;
  logic       sig0, busy0, sig1, busy1;
  logic [3:0] pend0;
  logic [1:0] pend1;
`ifdef EDGEGEN_OVERFLOW_EN
  logic       ovf0, ovf1;
`endif

  always #5 in_clk = ~in_clk;

  edgegen #(
    .HIGH_CYCLES(4), .LOW_CYCLES(4), .PENDING_BITS(4), .POS_EDGE(1)
  ) dut0 (
    .in_clk(in_clk), .in_rst(in_rst), .in_trigger(in_trigger),
    .out_signal(sig0), .out_busy(busy0), .out_pending(pend0)
`ifdef EDGEGEN_OVERFLOW_EN
    , .out_overflow(ovf0)
`endif
  );

  edgegen #(
    .HIGH_CYCLES(1), .LOW_CYCLES(2), .PENDING_BITS(2), .POS_EDGE(0)
  ) dut1 (
    .in_clk(in_clk), .in_rst(in_rst), .in_trigger(in_trigger),
    .out_signal(sig1), .out_busy(busy1), .out_pending(pend1)
`ifdef EDGEGEN_OVERFLOW_EN
    , .out_overflow(ovf1)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Model: every accepted trigger becomes (trigger cycle, start cycle).
  int HC[2]   = '{4, 1};
  int LC[2]   = '{4, 2};
  int PMAX[2] = '{15, 3};
  int POSL[2] = '{1, 0};
  int tr_a[2][64];
  int s_a[2][64];
  int cnt[2];
  int s_last[2];
  int ovf_at[2];
  int hi_run[2];
  int lo_run[2];
  bit seen[2];
  int cyc;

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      cnt[k]    = 0;
      s_last[k] = -1000;
      ovf_at[k] = 32'h7fffffff;
      hi_run[k] = 0;
      lo_run[k] = 0;
      seen[k]   = 1'b0;
    end
    cyc = 0;
  endtask

  task automatic model_trig(input int k);
    int n;
    int start;
    n = 0;
    if (cyc >= s_last[k] + HC[k] + LC[k]) begin
      start = cyc + 1;
    end else begin
      for (int i = 0; i < cnt[k]; i++)
        if (s_a[k][i] > cyc + 1) n++;
      if (n >= PMAX[k]) begin
        if (ovf_at[k] > cyc + 1) ovf_at[k] = cyc + 1;
        return;
      end
      start = (cyc == s_last[k] + HC[k] + LC[k] - 1) ? cyc + 2 : s_last[k] + HC[k] + LC[k];
    end
    if (cnt[k] < 64) begin
      tr_a[k][cnt[k]] = cyc;
      s_a[k][cnt[k]]  = start;
      cnt[k]++;
    end
    s_last[k] = start;
  endtask

  task automatic check_cycle();
    for (int k = 0; k < 2; k++) begin
      int   e_act, e_busy, e_pend, e_sig, j;
      logic g_sig, g_busy;
      int   g_pend;
      bit   act;
      e_act = 0; e_busy = 0; e_pend = 0;
      for (int i = 0; i < cnt[k]; i++) begin
        if (s_a[k][i] <= cyc && cyc < s_a[k][i] + HC[k]) e_act = 1;
        if (tr_a[k][i] < cyc && cyc <= s_a[k][i] + HC[k] + LC[k] - 1) e_busy = 1;
        if (tr_a[k][i] < cyc && cyc < s_a[k][i]) e_pend++;
      end
      e_sig  = (POSL[k] == 1) ? e_act : 1 - e_act;
      g_sig  = (k == 0) ? sig0 : sig1;
      g_busy = (k == 0) ? busy0 : busy1;
      g_pend = (k == 0) ? int'(pend0) : int'(pend1);
      check_eq($sformatf("signal%0d@%0d", k, cyc), {31'd0, g_sig}, e_sig);
      check_eq($sformatf("busy%0d@%0d", k, cyc), {31'd0, g_busy}, e_busy);
      check_eq($sformatf("pending%0d@%0d", k, cyc), g_pend, e_pend);
`ifdef EDGEGEN_OVERFLOW_EN
      check_eq($sformatf("overflow%0d@%0d", k, cyc), {31'd0, (k == 0) ? ovf0 : ovf1},
               (cyc >= ovf_at[k]) ? 1 : 0);
`endif
      act = (g_sig == POSL[k][0]);
      if (act) begin
        if (hi_run[k] == 0 && seen[k])
          check_eq($sformatf("min_gap%0d@%0d", k, cyc), (lo_run[k] >= LC[k]) ? 1 : 0, 1);
        hi_run[k]++;
        lo_run[k] = 0;
        seen[k]   = 1'b1;
      end else begin
        if (hi_run[k] > 0)
          check_eq($sformatf("width%0d@%0d", k, cyc), hi_run[k], HC[k]);
        hi_run[k] = 0;
        lo_run[k]++;
      end
      j = 0;
      for (int i = 0; i < cnt[k]; i++) begin
        if (s_a[k][i] + HC[k] + LC[k] - 1 >= cyc) begin
          tr_a[k][j] = tr_a[k][i];
          s_a[k][j]  = s_a[k][i];
          j++;
        end
      end
      cnt[k] = j;
    end
  endtask

  task automatic step(input bit trig);
    check_cycle();
    if (trig) begin
      model_trig(0);
      model_trig(1);
    end
    in_trigger = trig;
    @(negedge in_clk);
    cyc++;
  endtask

  task automatic check_idle_async(input string tag);
    check_eq({tag, "_sig0"}, {31'd0, sig0}, 0);
    check_eq({tag, "_sig1"}, {31'd0, sig1}, 1);
    check_eq({tag, "_busy0"}, {31'd0, busy0}, 0);
    check_eq({tag, "_busy1"}, {31'd0, busy1}, 0);
    check_eq({tag, "_pend0"}, {28'd0, pend0}, 0);
    check_eq({tag, "_pend1"}, {30'd0, pend1}, 0);
`ifdef EDGEGEN_OVERFLOW_EN
    check_eq({tag, "_ovf0"}, {31'd0, ovf0}, 0);
    check_eq({tag, "_ovf1"}, {31'd0, ovf1}, 0);
`endif
  endtask

  initial begin
    int p;
    in_rst     = 1'b1;
    in_trigger = 1'b0;
    repeat (3) @(negedge in_clk);
    check_idle_async("reset");
    in_rst = 1'b0;
    model_reset();

    // single trigger at cycle 10
    repeat (10) step(1'b0);
    step(1'b1);
    repeat (25) step(1'b0);

    // three consecutive triggers
    repeat (3) step(1'b1);
    repeat (40) step(1'b0);

    // held trigger: short burst, then long enough to saturate both queues
    repeat (6) step(1'b1);
    repeat (60) step(1'b0);
    repeat (20) step(1'b1);
    repeat (200) step(1'b0);

    // trigger in the last gap cycle of each configuration
    step(1'b1);
    repeat (7) step(1'b0);
    step(1'b1);
    repeat (30) step(1'b0);
    step(1'b1);
    repeat (2) step(1'b0);
    step(1'b1);
    repeat (30) step(1'b0);

    // asynchronous reset while dut0 is active with three queued
    repeat (4) step(1'b1);
    in_trigger = 1'b0;
    #2 in_rst = 1'b1;
    #1 check_idle_async("midreset");
    @(negedge in_clk);
    in_rst = 1'b0;
    model_reset();
    step(1'b1);
    repeat (15) step(1'b0);

    // random stream with changing trigger density
    p = 10;
    for (int n = 0; n < 3000; n++) begin
      if (n % 250 == 0) begin
        case ($urandom_range(3))
          0: p = 3;
          1: p = 15;
          2: p = 40;
          default: p = 90;
        endcase
      end
      step($urandom_range(99) < p);
    end
    repeat (200) step(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
